// File: rtl/mips_trace_buffer_if.sv
// Capture/control/readout bundle for mips_trace_buffer.
// rd_stamp exists only when TRACE_CYCLE_STAMP_EN is defined.
interface mips_trace_buffer_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);

    logic              cap_valid;
    logic [DATA_W-1:0] cap_pc;
    logic [DATA_W-1:0] cap_inst;
    logic [DATA_W-1:0] cap_alu;
    logic              arm;
    logic              stop;
    logic [DATA_W-1:0] trig_pc;
    logic              rd_req;
    logic [AW-1:0]     rd_idx;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_pc;
    logic [DATA_W-1:0] rd_inst;
    logic [DATA_W-1:0] rd_alu;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0]       rd_stamp;
`endif
    logic [1:0]        state;
    logic [AW:0]       count;
    logic              triggered;

    modport master (
`ifdef TRACE_CYCLE_STAMP_EN
        input  rd_stamp,
`endif
        output cap_valid, cap_pc, cap_inst, cap_alu, arm, stop, trig_pc, rd_req, rd_idx,
        input  rd_valid, rd_pc, rd_inst, rd_alu, state, count, triggered
    );

    modport slave (
`ifdef TRACE_CYCLE_STAMP_EN
        output rd_stamp,
`endif
        input  cap_valid, cap_pc, cap_inst, cap_alu, arm, stop, trig_pc, rd_req, rd_idx,
        output rd_valid, rd_pc, rd_inst, rd_alu, state, count, triggered
    );
endinterface

// File: rtl/mips_trace_buffer.sv
// Circular instruction-trace buffer with PC trigger, post-trigger window and oldest-first readout.
// Optional TRACE_CYCLE_STAMP_EN adds a per-entry 32-bit cycle stamp and rd_stamp output.
module mips_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int POST   = 4
) (
    input  logic                clk,
    input  logic                reset,
    mips_trace_buffer_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [AW-1:0]    POST_INIT = AW'(POST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [AW-1:0]     wr_ptr_r, wr_ptr_s;
    logic [CNT_W-1:0]  count_r, count_s;
    logic [AW-1:0]     post_cnt_r, post_cnt_s;
    logic              trig_r, trig_s;
    logic              wr_en_s;
    logic [AW-1:0]     oldest_s;
    logic [AW-1:0]     rd_addr_s;

    logic [DATA_W-1:0] mem_pc   [DEPTH];
    logic [DATA_W-1:0] mem_inst [DEPTH];
    logic [DATA_W-1:0] mem_alu  [DEPTH];

    logic              rd_valid_r;
    logic [DATA_W-1:0] rd_pc_r, rd_inst_r, rd_alu_r;

    // Control state registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            post_cnt_r <= {AW{1'b0}};
            trig_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            wr_ptr_r   <= wr_ptr_s;
            count_r    <= count_s;
            post_cnt_r <= post_cnt_s;
            trig_r     <= trig_s;
        end
    end

    // Next-state logic; arm overrides everything, stop suppresses the concurrent write
    always_comb begin
        state_s    = state_r;
        wr_ptr_s   = wr_ptr_r;
        count_s    = count_r;
        post_cnt_s = post_cnt_r;
        trig_s     = trig_r;
        wr_en_s    = 1'b0;
        if (bus.arm) begin
            state_s    = ST_ARMED;
            wr_ptr_s   = {AW{1'b0}};
            count_s    = {CNT_W{1'b0}};
            post_cnt_s = {AW{1'b0}};
            trig_s     = 1'b0;
        end else begin
            case (state_r)
                ST_ARMED, ST_POST: begin
                    if (bus.stop) begin
                        state_s = ST_DONE;
                    end else if (bus.cap_valid) begin
                        wr_en_s  = 1'b1;
                        wr_ptr_s = wr_ptr_r + AW'(1);
                        count_s  = (count_r == CNT_FULL) ? count_r : count_r + CNT_W'(1);
                        if (state_r == ST_ARMED) begin
                            if (bus.cap_pc == bus.trig_pc) begin
                                trig_s     = 1'b1;
                                post_cnt_s = POST_INIT;
                                state_s    = (POST == 0) ? ST_DONE : ST_POST;
                            end else begin
                                state_s = ST_ARMED;
                            end
                        end else begin
                            post_cnt_s = post_cnt_r - AW'(1);
                            state_s    = (post_cnt_r == AW'(1)) ? ST_DONE : ST_POST;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_IDLE: state_s = ST_IDLE;
                ST_DONE: state_s = ST_DONE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Oldest entry is slot 0 until the buffer has wrapped, then the write pointer
    always_comb begin
        if (count_r == CNT_FULL) begin
            oldest_s = wr_ptr_r;
        end else begin
            oldest_s = {AW{1'b0}};
        end
        rd_addr_s = oldest_s + bus.rd_idx;
    end

    // Trace storage; contents survive arm and reset
    always_ff @(posedge clk) begin
        if (reset && wr_en_s) begin
            mem_pc[wr_ptr_r]   <= bus.cap_pc;
            mem_inst[wr_ptr_r] <= bus.cap_inst;
            mem_alu[wr_ptr_r]  <= bus.cap_alu;
        end
    end

    // Registered readout, only while frozen; indices past count read as zero
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid_r <= 1'b0;
            rd_pc_r    <= {DATA_W{1'b0}};
            rd_inst_r  <= {DATA_W{1'b0}};
            rd_alu_r   <= {DATA_W{1'b0}};
        end else if (state_r == ST_DONE && bus.rd_req) begin
            rd_valid_r <= 1'b1;
            if ({1'b0, bus.rd_idx} < count_r) begin
                rd_pc_r   <= mem_pc[rd_addr_s];
                rd_inst_r <= mem_inst[rd_addr_s];
                rd_alu_r  <= mem_alu[rd_addr_s];
            end else begin
                rd_pc_r   <= {DATA_W{1'b0}};
                rd_inst_r <= {DATA_W{1'b0}};
                rd_alu_r  <= {DATA_W{1'b0}};
            end
        end else begin
            rd_valid_r <= 1'b0;
        end
    end

`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] cyc_r;
    logic [31:0] mem_stamp [DEPTH];
    logic [31:0] rd_stamp_r;

    // Free-running cycle counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            cyc_r <= 32'd0;
        end else begin
            cyc_r <= cyc_r + 32'd1;
        end
    end

    // Stamp storage alongside each record
    always_ff @(posedge clk) begin
        if (reset && wr_en_s) begin
            mem_stamp[wr_ptr_r] <= cyc_r;
        end
    end

    // Stamp readout mirrors the other read fields
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_stamp_r <= 32'd0;
        end else if (state_r == ST_DONE && bus.rd_req) begin
            rd_stamp_r <= ({1'b0, bus.rd_idx} < count_r) ? mem_stamp[rd_addr_s] : 32'd0;
        end
    end

    assign bus.rd_stamp = rd_stamp_r;
`endif

    assign bus.rd_valid  = rd_valid_r;
    assign bus.rd_pc     = rd_pc_r;
    assign bus.rd_inst   = rd_inst_r;
    assign bus.rd_alu    = rd_alu_r;
    assign bus.state     = state_r;
    assign bus.count     = count_r;
    assign bus.triggered = trig_r;
endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer: two instances (POST=4 and POST=0) with a read scoreboard.
module tb_mips_trace_buffer;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mips_trace_buffer_if #(.DATA_W(DW), .DEPTH(DEPTH)) ifa ();
    mips_trace_buffer_if #(.DATA_W(DW), .DEPTH(DEPTH)) ifb ();

    mips_trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .POST(4)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave));
    mips_trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .POST(0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave));

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu;
        logic [31:0] stamp;
        bit          has_stamp;
    } rec_t;

    rec_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] tb_cyc = 32'd0;

    // Reference cycle count: edges since reset was released
    always @(posedge clk) begin
        if (!reset) tb_cyc <= 32'd0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] alu_of(input logic [31:0] pc);
        return pc + 32'h0000_1000;
    endfunction

    function automatic rec_t mkrec(input logic [31:0] pc);
        rec_t r;
        r.pc = pc; r.inst = inst_of(pc); r.alu = alu_of(pc); r.stamp = 32'd0; r.has_stamp = 1'b0;
        return r;
    endfunction

    function automatic rec_t zrec();
        rec_t r;
        r.pc = 32'd0; r.inst = 32'd0; r.alu = 32'd0; r.stamp = 32'd0; r.has_stamp = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifa.cap_valid = 1'b0; ifa.cap_pc = '0; ifa.cap_inst = '0; ifa.cap_alu = '0;
        ifa.arm = 1'b0; ifa.stop = 1'b0; ifa.trig_pc = '0; ifa.rd_req = 1'b0; ifa.rd_idx = '0;
        ifb.cap_valid = 1'b0; ifb.cap_pc = '0; ifb.cap_inst = '0; ifb.cap_alu = '0;
        ifb.arm = 1'b0; ifb.stop = 1'b0; ifb.trig_pc = '0; ifb.rd_req = 1'b0; ifb.rd_idx = '0;
    endtask

    task automatic arm_pulse(input bit sel);
        if (sel) ifb.arm = 1'b1; else ifa.arm = 1'b1;
        step();
        ifa.arm = 1'b0; ifb.arm = 1'b0;
    endtask

    task automatic cap(input bit sel, input logic [31:0] pc);
        if (sel) begin
            ifb.cap_valid = 1'b1; ifb.cap_pc = pc; ifb.cap_inst = inst_of(pc); ifb.cap_alu = alu_of(pc);
        end else begin
            ifa.cap_valid = 1'b1; ifa.cap_pc = pc; ifa.cap_inst = inst_of(pc); ifa.cap_alu = alu_of(pc);
        end
        step();
        ifa.cap_valid = 1'b0; ifb.cap_valid = 1'b0;
    endtask

    task automatic stop_pulse();
        ifa.stop = 1'b1;
        step();
        ifa.stop = 1'b0;
    endtask

    // Issue one read, push its expectation, then pop and compare one cycle later
    task automatic rd(input bit sel, input logic [3:0] idx, input rec_t exp_r, input string tag);
        rec_t e;
        logic v;
        logic [31:0] pc, inst, alu;
        if (sel) begin ifb.rd_req = 1'b1; ifb.rd_idx = idx; end
        else     begin ifa.rd_req = 1'b1; ifa.rd_idx = idx; end
        sb_q.push_back(exp_r);
        step();
        ifa.rd_req = 1'b0; ifb.rd_req = 1'b0;
        v    = sel ? ifb.rd_valid : ifa.rd_valid;
        pc   = sel ? ifb.rd_pc    : ifa.rd_pc;
        inst = sel ? ifb.rd_inst  : ifa.rd_inst;
        alu  = sel ? ifb.rd_alu   : ifa.rd_alu;
        chk({tag, "_valid"}, 64'(v), 64'd1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_pc"}, 64'(pc), 64'(e.pc));
            chk({tag, "_inst"}, 64'(inst), 64'(e.inst));
            chk({tag, "_alu"}, 64'(alu), 64'(e.alu));
`ifdef TRACE_CYCLE_STAMP_EN
            if (e.has_stamp) chk({tag, "_stamp"}, 64'(sel ? ifb.rd_stamp : ifa.rd_stamp), 64'(e.stamp));
`endif
        end
    endtask

    initial begin
        rec_t r;
        clear_inputs();
        reset = 1'b0;
        step(); step();
        chk("reset_state", 64'(ifa.state), 64'd0);
        chk("reset_count", 64'(ifa.count), 64'd0);
        chk("reset_trig", 64'(ifa.triggered), 64'd0);
        chk("reset_rdv", 64'(ifa.rd_valid), 64'd0);
        chk("reset_rdpc", 64'(ifa.rd_pc), 64'd0);
        reset = 1'b1;

`ifdef TRACE_CYCLE_STAMP_EN
        ifa.trig_pc = 32'hFFFF_FFF0;
        for (int i = 0; i < 40 && tb_cyc != 32'd10; i++) step();
        arm_pulse(1'b0);
        for (int i = 0; i < 40 && tb_cyc != 32'd12; i++) step();
        cap(1'b0, 32'h200);
        for (int i = 0; i < 40 && tb_cyc != 32'd15; i++) step();
        cap(1'b0, 32'h204);
        stop_pulse();
        r = mkrec(32'h200); r.stamp = 32'd12; r.has_stamp = 1'b1;
        rd(1'b0, 4'd0, r, "stamp0");
        r = mkrec(32'h204); r.stamp = 32'd15; r.has_stamp = 1'b1;
        rd(1'b0, 4'd1, r, "stamp1");
`endif

        // No trigger: five records, then stop with a concurrent record that must be dropped
        ifa.trig_pc = 32'hFFFF_FFF0;
        arm_pulse(1'b0);
        for (int i = 0; i < 5; i++) cap(1'b0, 32'(i * 4));
        chk("notrig_state", 64'(ifa.state), 64'd1);
        chk("notrig_count", 64'(ifa.count), 64'd5);
        chk("notrig_trig", 64'(ifa.triggered), 64'd0);
        ifa.stop = 1'b1;
        cap(1'b0, 32'h14);
        ifa.stop = 1'b0;
        chk("stop_state", 64'(ifa.state), 64'd3);
        chk("stop_count", 64'(ifa.count), 64'd5);
        for (int i = 0; i < 5; i++) rd(1'b0, 4'(i), mkrec(32'(i * 4)), "notrig_rd");
        rd(1'b0, 4'd5, zrec(), "notrig_rd_beyond");
        rd(1'b0, 4'd15, zrec(), "notrig_rd_top");
        step();
        chk("rdv_one_cycle", 64'(ifa.rd_valid), 64'd0);

        // Trigger at 0x40 with four post records and wrap-around
        ifa.trig_pc = 32'h40;
        arm_pulse(1'b0);
        chk("arm_state", 64'(ifa.state), 64'd1);
        chk("arm_count", 64'(ifa.count), 64'd0);
        chk("arm_trig", 64'(ifa.triggered), 64'd0);
        for (int i = 0; i < 64; i++) begin
            cap(1'b0, 32'(i * 4));
            if (i * 4 == 32'h3C) chk("pre_trig_state", 64'(ifa.state), 64'd1);
            if (i * 4 == 32'h40) chk("trig_state", 64'(ifa.state), 64'd2);
            if (i * 4 == 32'h40) chk("trig_flag", 64'(ifa.triggered), 64'd1);
            if (i * 4 == 32'h4C) chk("post_state", 64'(ifa.state), 64'd2);
            if (i * 4 == 32'h50) chk("done_state", 64'(ifa.state), 64'd3);
        end
        chk("wrap_count", 64'(ifa.count), 64'd16);
        chk("wrap_trig", 64'(ifa.triggered), 64'd1);
        stop_pulse();
        chk("stop_in_done", 64'(ifa.state), 64'd3);
        for (int i = 0; i < 16; i++) rd(1'b0, 4'(i), mkrec(32'(32'h14 + i * 4)), "wrap_rd");

        // arm and stop together in POST: arm wins
        ifa.trig_pc = 32'h8;
        arm_pulse(1'b0);
        cap(1'b0, 32'h0); cap(1'b0, 32'h4); cap(1'b0, 32'h8);
        chk("as_pre_state", 64'(ifa.state), 64'd2);
        chk("as_pre_count", 64'(ifa.count), 64'd3);
        ifa.stop = 1'b1;
        arm_pulse(1'b0);
        ifa.stop = 1'b0;
        chk("as_state", 64'(ifa.state), 64'd1);
        chk("as_count", 64'(ifa.count), 64'd0);
        chk("as_trig", 64'(ifa.triggered), 64'd0);

        // Reset in POST with count 7, then a read request in IDLE
        ifa.trig_pc = 32'h18;
        for (int i = 0; i < 7; i++) cap(1'b0, 32'(i * 4));
        chk("rst_pre_state", 64'(ifa.state), 64'd2);
        chk("rst_pre_count", 64'(ifa.count), 64'd7);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst_state", 64'(ifa.state), 64'd0);
        chk("rst_count", 64'(ifa.count), 64'd0);
        chk("rst_rdv", 64'(ifa.rd_valid), 64'd0);
        chk("rst_trig", 64'(ifa.triggered), 64'd0);
        ifa.rd_req = 1'b1;
        ifa.rd_idx = 4'd0;
        step();
        ifa.rd_req = 1'b0;
        chk("idle_rd_ignored", 64'(ifa.rd_valid), 64'd0);

        // POST=0 instance: trigger on the first record freezes immediately
        ifb.trig_pc = 32'h100;
        arm_pulse(1'b1);
        cap(1'b1, 32'h100);
        chk("p0_state", 64'(ifb.state), 64'd3);
        chk("p0_count", 64'(ifb.count), 64'd1);
        chk("p0_trig", 64'(ifb.triggered), 64'd1);
        rd(1'b1, 4'd1, zrec(), "p0_rd_beyond");
        rd(1'b1, 4'd0, mkrec(32'h100), "p0_rd0");
        cap(1'b1, 32'h104);
        chk("p0_frozen_count", 64'(ifb.count), 64'd1);

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
